// File: rtl/audio_pkg.sv
// Shared constants, FSM state type and tone table for the audio sample generator.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PHASE_W  = 24;

  localparam logic [15:0] SQ_POS = 16'h4000;
  localparam logic [15:0] SQ_NEG = 16'hC000;

  typedef enum logic [1:0] {
    StIdle,
    StPresentL,
    StPresentR
  } state_e;

  // Per-tick phase increments for 220/440/880/1000 Hz at ~44.1 kHz.
  function automatic logic [PHASE_W-1:0] phase_inc(input logic [1:0] sel);
    logic [PHASE_W-1:0] inc;
    unique case (sel)
      2'd0: inc = 24'd83712;
      2'd1: inc = 24'd167424;
      2'd2: inc = 24'd334848;
      default: inc = 24'd380510;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/audio_tick_div.sv
// Sample-rate divider: one-cycle registered tick every CLK_DIV clocks.
module audio_tick_div #(
  parameter int unsigned CLK_DIV = 2268
) (
  input  logic CLK,
  input  logic Reset,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CntW'(CLK_DIV - 1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_sample_gen.sv
// Tone generator presenting L/R sample pairs to an I2S serializer.
// Define AUDIO_SAMPLE_GEN_SAW_EN to enable the sawtooth waveform (control bit [2]).
module audio_sample_gen #(
  parameter int unsigned CLK_DIV  = 2268,
  parameter int unsigned SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int unsigned PHASE_W  = audio_pkg::PHASE_W
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [3:0]          AudioControlRegister,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_chan,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);

  import audio_pkg::*;

  logic                tick;
  state_e              state_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [PHASE_W-1:0]  phase_next;
  logic [SAMPLE_W-1:0] sample_next;
  logic [SAMPLE_W-1:0] sq_sample;

  audio_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .CLK  (CLK),
    .Reset(Reset),
    .tick (tick)
  );

`ifndef AUDIO_SAMPLE_GEN_SAW_EN
  logic unused_wave;
  assign unused_wave = AudioControlRegister[2];
`endif

  // Control is only consumed here, at the IDLE tick, so a pair never mixes settings.
  always_comb begin
    phase_next  = AudioControlRegister[3] ?
                  phase_q + PHASE_W'(phase_inc(AudioControlRegister[1:0])) : '0;
    sq_sample   = phase_next[PHASE_W-1] ? SAMPLE_W'(SQ_NEG) : SAMPLE_W'(SQ_POS);
    sample_next = '0;
    if (AudioControlRegister[3]) begin
`ifdef AUDIO_SAMPLE_GEN_SAW_EN
      if (AudioControlRegister[2]) begin
        sample_next = {~phase_next[PHASE_W-1], phase_next[PHASE_W-2 -: SAMPLE_W-1]};
      end else begin
        sample_next = sq_sample;
      end
`else
      sample_next = sq_sample;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      sample_data  <= '0;
      sample_chan  <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            phase_q      <= phase_next;
            sample_data  <= sample_next;
            sample_chan  <= 1'b0;
            sample_valid <= 1'b1;
            state_q      <= StPresentL;
          end
        end
        StPresentL: begin
          if (tick) overrun <= 1'b1;
          if (sample_ready) begin
            sample_chan <= 1'b1;
            state_q     <= StPresentR;
          end
        end
        StPresentR: begin
          if (tick) overrun <= 1'b1;
          if (sample_ready) begin
            sample_chan  <= 1'b0;
            sample_valid <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/audio_sample_gen.md
AUDIO_SAMPLE_GEN -- requirements
Module: audio_sample_gen

Interface
REQ-001 Parameter: CLK_DIV, default 2268, system clocks per sample period (100 MHz / 2268 ≈ 44.09 kHz).
REQ-002 Parameter: SAMPLE_W, default 16, sample width in bits, two's complement.
REQ-003 Parameter: PHASE_W, default 24, phase accumulator width.
REQ-004 Port: CLK  in  1  system clock; all logic on its rising edge.
REQ-005 Port: Reset  in  1  synchronous, active-low reset.
REQ-006 Port: AudioControlRegister  in  4  [3] enable, [2] waveform (0 square, 1 saw), [1:0] tone select.
REQ-007 Port: sample_data  out  SAMPLE_W  sample offered to the I2S serializer.
REQ-008 Port: sample_chan  out  1  0 = left, 1 = right.
REQ-009 Port: sample_valid  out  1  sample_data/sample_chan are valid.
REQ-010 Port: sample_ready  in  1  I2S serializer accepts the current sample.
REQ-011 Port: overrun  out  1  sticky: a sample tick occurred while a sample was still pending.

Function
REQ-012 The tick divider SHALL assert a one-cycle tick every CLK_DIV cycles, with the first tick CLK_DIV cycles after reset release.
REQ-013 The FSM SHALL have states IDLE, PRESENT_L and PRESENT_R; IDLE→PRESENT_L on tick; PRESENT_L→PRESENT_R on valid&ready; PRESENT_R→IDLE on valid&ready.
REQ-014 sample_valid SHALL be 1 exactly in PRESENT_L/PRESENT_R; sample_chan SHALL be 0 in PRESENT_L and 1 in PRESENT_R.
REQ-015 sample_data and sample_chan SHALL stay stable while sample_valid=1 and ready=0.
REQ-016 On each tick, the phase SHALL add the increment for tone select, mod 2^PHASE_W: 0→83712 (220 Hz), 1→167424 (440 Hz), 2→334848 (880 Hz), 3→380510 (1000 Hz).
REQ-017 The sample value SHALL be computed from the updated phase and latched on the IDLE→PRESENT_L transition; L and R SHALL carry the same value.
REQ-018 Square: sample = phase[MSB] ? 16'hC000 : 16'h4000.
REQ-019 Saw: sample = {~phase[PHASE_W-1], phase[PHASE_W-2 -: SAMPLE_W-1]}.
REQ-020 With enable=0, the phase SHALL be held at 0 and samples SHALL be 16'h0000, with the handshake continuing.
REQ-021 Control changes SHALL take effect only at the next tick, never mid-pair.
REQ-022 A tick outside IDLE SHALL set overrun, SHALL be dropped (no phase update), and SHALL NOT disturb the pending pair.
REQ-023 The phase SHALL wrap silently from 2^PHASE_W-1 to 0.
REQ-024 Latency from tick to sample_valid=1 SHALL be one cycle.

Reset
REQ-025 On Reset=0 at a clock edge: FSM IDLE, phase 0, divider 0, sample_data 0, sample_chan 0, sample_valid 0, overrun 0.
REQ-026 Reset mid-handshake SHALL drop the pending sample; no partial pair SHALL be emitted afterwards.
REQ-027 overrun SHALL be cleared only by reset.

Configuration
REQ-028 With macro AUDIO_SAMPLE_GEN_SAW_EN defined, control bit [2] SHALL select square or saw per REQ-018/019.
REQ-029 Without AUDIO_SAMPLE_GEN_SAW_EN, bit [2] SHALL be ignored, output SHALL always be square, and no saw logic SHALL be synthesised.

Structure
REQ-030 Shared package audio_pkg SHALL hold SAMPLE_W, PHASE_W, the FSM state enum, the four-entry phase-increment table, and the square amplitude constants.
REQ-031 The divider SHALL be the sub-module audio_tick_div (params CLK_DIV; ports CLK, Reset, tick).

Verification
REQ-032 Reset 5 cycles, then release, control 4'b1000, ready tied 1 -> first valid at cycle CLK_DIV+1; data 16'h4000 for L then R; sample_chan 0 then 1; overrun stays 0.
REQ-033 control 4'b1001, ready 1, run 100 ticks -> phase = 100*167424 mod 2^24 = 16742400, and square output matches phase MSB on every pair.
REQ-034 Valid asserted, ready held 0 for 3000 cycles -> data/chan frozen, overrun=1 after the next tick, and phase unchanged by the dropped tick.
REQ-035 With AUDIO_SAMPLE_GEN_SAW_EN, control 4'b1111, phase 0 -> first sample {~phase[23], phase[22:8]} of 380510 = 16'h85CE; without the macro, 16'h4000.
REQ-036 Reset=0 asserted while in PRESENT_R -> next edge: valid 0, phase 0; after release, the first pair starts with chan 0.
REQ-037 control 4'b0011 -> every sample 16'h0000; then switch to 4'b1011 mid-pair -> the current pair stays 0, and the next tick gives phase 380510.
